// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared IFU types for the I-cache diagnostic path. Holds the
//               state encoding of the diag controller, the TLU diag packet
//               layout, and the default array geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Default I-cache geometry
  localparam int IFU_IC_IDX_W  = 9;
  localparam int IFU_IC_WAYS   = 4;
  localparam int IFU_IC_DATA_W = 71;
  localparam int IFU_IC_WAY_W  = $clog2(IFU_IC_WAYS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } ic_diag_state_e;

  // TLU diag packet, sized for the default geometry
  typedef struct packed {
    logic                     rd_valid;
    logic                     wr_valid;
    logic                     tag_sel;
    logic [IFU_IC_WAY_W-1:0]  way;
    logic [IFU_IC_IDX_W-1:0]  index;
    logic [IFU_IC_DATA_W-1:0] wrdata;
  } ic_diag_pkt_t;

endpackage
`default_nettype wire

// File: rtl/ifu_ic_diag_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ifu_ic_diag_lat_cnt
// Description : Array read-latency down-counter. Loaded during the issue
//               cycle, counts down while enabled, and raises done in the last
//               wait cycle (the cycle whose end samples the array data).
// Ports       : clk, rst_l (async active-low), load, en -> done
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_ic_diag_lat_cnt #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int            c_cnt_w = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(RD_LAT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ifu_ic_diag_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_ic_diag_ctl
// Description : IFU responder for TLU I-cache diagnostic reads/writes.
//               Captures one request, arbitrates against fetch (requesting a
//               fetch hold on starvation), issues a one-cycle array access
//               and returns read data with a one-cycle valid pulse.
// Ports       : dec_tlu_ic_diag_*  - request from TLU
//               ifc_fetch_active   - fetch owns the array
//               ic_array_rd_data   - array read return
//               ic_debug_*         - array access strobes/address/data
//               ifu_ic_diag_*, ifu_ic_debug_* - status and read return
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_ic_diag_ctl
  import ifu_pkg::*;
#(
  parameter int IDX_W      = IFU_IC_IDX_W,
  parameter int WAYS       = IFU_IC_WAYS,
  parameter int DATA_W     = IFU_IC_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 15
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    dec_tlu_ic_diag_rd_valid,
  input  logic                    dec_tlu_ic_diag_wr_valid,
  input  logic                    dec_tlu_ic_diag_tag_sel,
  input  logic [$clog2(WAYS)-1:0] dec_tlu_ic_diag_way,
  input  logic [IDX_W-1:0]        dec_tlu_ic_diag_index,
  input  logic [DATA_W-1:0]       dec_tlu_ic_diag_wrdata,
  input  logic                    ifc_fetch_active,
  input  logic [DATA_W-1:0]       ic_array_rd_data,
  output logic                    ic_debug_rd_en,
  output logic                    ic_debug_wr_en,
  output logic                    ic_debug_tag_array,
  output logic [WAYS-1:0]         ic_debug_way,
  output logic [IDX_W-1:0]        ic_debug_addr,
  output logic [DATA_W-1:0]       ic_debug_wr_data,
  output logic                    ifu_ic_diag_fetch_hold,
  output logic [DATA_W-1:0]       ifu_ic_debug_rd_data,
  output logic                    ifu_ic_debug_rd_data_valid,
  output logic                    ifu_ic_diag_busy,
  output logic                    ifu_ic_diag_err
);

  localparam int                c_way_w       = $clog2(WAYS);
  localparam int                c_sc_w        = $clog2(STARVE_LIM + 1);
  localparam logic [c_sc_w-1:0] c_starve_lim  = c_sc_w'(STARVE_LIM);

  ic_diag_state_e      r_state, w_state_next;

  // Captured request
  logic                r_op_wr, r_tag_sel;
  logic [c_way_w-1:0]  r_way;
  logic [IDX_W-1:0]    r_index;
  logic [DATA_W-1:0]   r_wrdata;

  logic [c_sc_w-1:0]   r_starve_cnt, w_starve_next;
  logic                w_req, w_lat_done;

  // Registered outputs and their next values
  logic                r_rd_en, r_wr_en, r_tag, r_hold, r_valid, r_busy, r_err;
  logic [WAYS-1:0]     r_way_oh;
  logic [IDX_W-1:0]    r_addr;
  logic [DATA_W-1:0]   r_wr_data, r_rd_data;
  logic                w_issue_n, w_rd_en_n, w_wr_en_n, w_tag_n, w_hold_n;
  logic                w_valid_n, w_busy_n, w_err_n;
  logic [WAYS-1:0]     w_way_n;
  logic [IDX_W-1:0]    w_addr_n;
  logic [DATA_W-1:0]   w_wr_data_n;

  assign w_req = dec_tlu_ic_diag_rd_valid | dec_tlu_ic_diag_wr_valid;

  ifu_ic_diag_lat_cnt #(.RD_LAT(RD_LAT)) u_lat_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .load  (r_state == ST_ISSUE),
    .en    (r_state == ST_WAIT),
    .done  (w_lat_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_req) w_state_next = ST_ARB;
      ST_ARB:   if (!ifc_fetch_active) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = r_op_wr ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (w_lat_done) w_state_next = ST_RESP;
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Starvation count runs only while arbitrating, saturating at the limit
  assign w_starve_next = (r_state != ST_ARB)            ? '0 :
                         (r_starve_cnt == c_starve_lim) ? r_starve_cnt :
                                                          r_starve_cnt + 1'b1;

  // Output logic: outputs are registered, so they are decoded from the
  // next state to line up with the state they describe.
  always_comb begin
    w_issue_n   = (w_state_next == ST_ISSUE);
    w_rd_en_n   = w_issue_n && !r_op_wr;
    w_wr_en_n   = w_issue_n && r_op_wr;
    w_tag_n     = w_issue_n && r_tag_sel;
    w_way_n     = w_issue_n ? (WAYS'(1) << r_way) : '0;
    w_addr_n    = w_issue_n ? r_index : '0;
    w_wr_data_n = w_wr_en_n ? r_wrdata : '0;
    w_busy_n    = (w_state_next != ST_IDLE);
    w_valid_n   = (w_state_next == ST_RESP);
    // In IDLE only a rd+wr collision drops a request; elsewhere any request
    w_err_n     = (r_state == ST_IDLE) ?
                  (dec_tlu_ic_diag_rd_valid & dec_tlu_ic_diag_wr_valid) : w_req;
    // Hold, once raised, persists through the issue cycle
    w_hold_n    = ((w_state_next == ST_ARB) || (w_state_next == ST_ISSUE)) &&
                  (r_hold || (w_starve_next == c_starve_lim));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_op_wr      <= 1'b0;
      r_tag_sel    <= 1'b0;
      r_way        <= '0;
      r_index      <= '0;
      r_wrdata     <= '0;
      r_starve_cnt <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_tag        <= 1'b0;
      r_way_oh     <= '0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_hold       <= 1'b0;
      r_rd_data    <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_req) begin
        // Write wins a rd/wr collision
        r_op_wr   <= dec_tlu_ic_diag_wr_valid;
        r_tag_sel <= dec_tlu_ic_diag_tag_sel;
        r_way     <= dec_tlu_ic_diag_way;
        r_index   <= dec_tlu_ic_diag_index;
        r_wrdata  <= dec_tlu_ic_diag_wrdata;
      end
      if (w_lat_done) r_rd_data <= ic_array_rd_data;
      r_starve_cnt <= w_starve_next;
      r_rd_en      <= w_rd_en_n;
      r_wr_en      <= w_wr_en_n;
      r_tag        <= w_tag_n;
      r_way_oh     <= w_way_n;
      r_addr       <= w_addr_n;
      r_wr_data    <= w_wr_data_n;
      r_hold       <= w_hold_n;
      r_valid      <= w_valid_n;
      r_busy       <= w_busy_n;
      r_err        <= w_err_n;
    end
  end

  assign ic_debug_rd_en             = r_rd_en;
  assign ic_debug_wr_en             = r_wr_en;
  assign ic_debug_tag_array         = r_tag;
  assign ic_debug_way               = r_way_oh;
  assign ic_debug_addr              = r_addr;
  assign ic_debug_wr_data           = r_wr_data;
  assign ifu_ic_diag_fetch_hold     = r_hold;
  assign ifu_ic_debug_rd_data       = r_rd_data;
  assign ifu_ic_debug_rd_data_valid = r_valid;
  assign ifu_ic_diag_busy           = r_busy;
  assign ifu_ic_diag_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_ic_diag_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_ic_diag_ctl
// Description : Directed self-checking bench for ifu_ic_diag_ctl. Expected
//               read data is queued when a read is requested and popped when
//               the valid pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_ic_diag_ctl;
  import ifu_pkg::*;

  localparam int IDX_W  = IFU_IC_IDX_W;
  localparam int WAYS   = IFU_IC_WAYS;
  localparam int DATA_W = IFU_IC_DATA_W;
  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rst_l = 1'b0;
  logic                    rd_valid = 1'b0, wr_valid = 1'b0, tag_sel = 1'b0;
  logic [$clog2(WAYS)-1:0] way = '0;
  logic [IDX_W-1:0]        index = '0;
  logic [DATA_W-1:0]       wrdata = '0;
  logic                    fetch_active = 1'b0;
  logic [DATA_W-1:0]       arr_rd_data = '0;

  logic                    ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array;
  logic [WAYS-1:0]         ic_debug_way;
  logic [IDX_W-1:0]        ic_debug_addr;
  logic [DATA_W-1:0]       ic_debug_wr_data, rd_data;
  logic                    fetch_hold, rd_valid_o, busy, err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_ic_diag_ctl #(
    .IDX_W(IDX_W), .WAYS(WAYS), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIM(15)
  ) dut (
    .clk                        (clk),
    .rst_l                      (rst_l),
    .dec_tlu_ic_diag_rd_valid   (rd_valid),
    .dec_tlu_ic_diag_wr_valid   (wr_valid),
    .dec_tlu_ic_diag_tag_sel    (tag_sel),
    .dec_tlu_ic_diag_way        (way),
    .dec_tlu_ic_diag_index      (index),
    .dec_tlu_ic_diag_wrdata     (wrdata),
    .ifc_fetch_active           (fetch_active),
    .ic_array_rd_data           (arr_rd_data),
    .ic_debug_rd_en             (ic_debug_rd_en),
    .ic_debug_wr_en             (ic_debug_wr_en),
    .ic_debug_tag_array         (ic_debug_tag_array),
    .ic_debug_way               (ic_debug_way),
    .ic_debug_addr              (ic_debug_addr),
    .ic_debug_wr_data           (ic_debug_wr_data),
    .ifu_ic_diag_fetch_hold     (fetch_hold),
    .ifu_ic_debug_rd_data       (rd_data),
    .ifu_ic_debug_rd_data_valid (rd_valid_o),
    .ifu_ic_diag_busy           (busy),
    .ifu_ic_diag_err            (err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: step past the edge; array returns junk unless overridden
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    arr_rd_data = DATA_W'(32'hDEAD0000 + 32'(cyc));
  endtask

  task automatic req(input ic_diag_pkt_t p);
    rd_valid = p.rd_valid;
    wr_valid = p.wr_valid;
    tag_sel  = p.tag_sel;
    way      = p.way;
    index    = p.index;
    wrdata   = p.wrdata;
  endtask

  task automatic idle_in();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
  endtask

  // Scoreboard drain on each valid pulse
  always @(negedge clk) begin
    if (rst_l && rd_valid_o) begin
      vcnt++;
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else                   chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  logic [161:0] all_out;
  assign all_out = {ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array, ic_debug_way,
                    ic_debug_addr, ic_debug_wr_data, fetch_hold, rd_data, rd_valid_o,
                    busy, err};

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    chk("reset_outputs", all_out, 0);
    rst_l = 1'b1;
    tick(); tick();
    chk("idle_busy", busy, 0);

    // ---------------- uncontended read ----------------
    req('{rd_valid:1'b1, wr_valid:1'b0, tag_sel:1'b1, way:2'd2, index:9'h1A5, wrdata:'0});
    exp_q.push_back(DATA_W'(8'h3F));
    tick(); idle_in();                                   // N+1
    chk("rd_busy_n1", busy, 1);
    chk("rd_err_n1", err, 0);
    chk("rd_en_n1", ic_debug_rd_en, 0);
    tick();                                              // N+2
    chk("rd_en_n2", {ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array}, 3'b101);
    chk("rd_way_n2", ic_debug_way, 4'b0100);
    chk("rd_addr_n2", ic_debug_addr, 9'h1A5);
    chk("rd_wrdata_n2", ic_debug_wr_data, 0);
    tick();                                              // N+3
    chk("rd_en_n3", ic_debug_rd_en, 0);
    tick(); arr_rd_data = DATA_W'(8'h3F);                // N+4 sample cycle
    tick();                                              // N+5
    chk("rd_valid_n5", rd_valid_o, 1);
    chk("rd_data_n5", rd_data, 8'h3F);
    tick();                                              // N+6
    chk("rd_valid_n6", rd_valid_o, 0);
    chk("rd_busy_n6", busy, 0);
    chk("rd_data_hold", rd_data, 8'h3F);

    // ---------------- write ----------------
    req('{rd_valid:1'b0, wr_valid:1'b1, tag_sel:1'b0, way:2'd1, index:9'h003, wrdata:DATA_W'(20'h12345)});
    tick(); idle_in();                                   // N+1
    tick();                                              // N+2
    chk("wr_en_n2", {ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array}, 3'b010);
    chk("wr_data_n2", ic_debug_wr_data, 20'h12345);
    chk("wr_way_n2", ic_debug_way, 4'b0010);
    chk("wr_addr_n2", ic_debug_addr, 9'h003);
    tick();                                              // N+3
    chk("wr_en_n3", ic_debug_wr_en, 0);
    tick();                                              // N+4
    chk("wr_busy_n4", busy, 0);
    chk("wr_no_valid", vcnt, 1);

    // ---------------- starvation ----------------
    fetch_active = 1'b1;
    req('{rd_valid:1'b1, wr_valid:1'b0, tag_sel:1'b0, way:2'd3, index:9'h0FF, wrdata:'0});
    exp_q.push_back(DATA_W'(20'h7ABCD));
    for (int k = 1; k <= 21; k++) begin
      tick(); idle_in();
      if (k == 21) fetch_active = 1'b0;
      chk($sformatf("hold_k%0d", k), fetch_hold, (k >= 16) ? 1 : 0);
      chk($sformatf("st_rd_en_k%0d", k), ic_debug_rd_en, 0);
    end
    tick();                                              // N+22 issue
    chk("st_rd_en_issue", ic_debug_rd_en, 1);
    chk("st_hold_issue", fetch_hold, 1);
    chk("st_way_issue", ic_debug_way, 4'b1000);
    tick();                                              // N+23
    chk("st_hold_clear", fetch_hold, 0);
    chk("st_rd_en_off", ic_debug_rd_en, 0);
    tick(); arr_rd_data = DATA_W'(20'h7ABCD);            // N+24 sample cycle
    tick();                                              // N+25
    chk("st_valid", rd_valid_o, 1);
    tick();
    chk("st_idle", busy, 0);

    // ---------------- simultaneous rd+wr ----------------
    req('{rd_valid:1'b1, wr_valid:1'b1, tag_sel:1'b0, way:2'd0, index:9'h010, wrdata:DATA_W'(12'hABC)});
    tick(); idle_in();                                   // N+1
    chk("col_err_n1", err, 1);
    chk("col_busy_n1", busy, 1);
    tick();                                              // N+2
    chk("col_strobes", {ic_debug_rd_en, ic_debug_wr_en}, 2'b01);
    chk("col_way", ic_debug_way, 4'b0001);
    chk("col_wrdata", ic_debug_wr_data, 12'hABC);
    tick();
    chk("col_err_n3", err, 0);
    tick(); tick();
    chk("col_no_valid", vcnt, 2);

    // ---------------- request during WAIT ----------------
    req('{rd_valid:1'b1, wr_valid:1'b0, tag_sel:1'b0, way:2'd1, index:9'h055, wrdata:'0});
    exp_q.push_back(DATA_W'(16'h1111));
    tick(); idle_in();                                   // N+1
    tick();                                              // N+2
    chk("bz_issue", ic_debug_rd_en, 1);
    tick();                                              // N+3 WAIT
    req('{rd_valid:1'b1, wr_valid:1'b0, tag_sel:1'b1, way:2'd3, index:9'h066, wrdata:'0});
    tick(); idle_in(); arr_rd_data = DATA_W'(16'h1111);  // N+4
    chk("bz_err", err, 1);
    tick();                                              // N+5
    chk("bz_valid", rd_valid_o, 1);
    chk("bz_err_clear", err, 0);
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk($sformatf("bz_no_access_n%0d", k), {ic_debug_rd_en, ic_debug_wr_en, busy}, 0);
    end
    chk("bz_one_valid", vcnt, 3);

    // ---------------- reset during WAIT ----------------
    req('{rd_valid:1'b1, wr_valid:1'b0, tag_sel:1'b0, way:2'd0, index:9'h001, wrdata:'0});
    tick(); idle_in();
    tick();
    chk("rs_issue", ic_debug_rd_en, 1);
    tick();                                              // WAIT
    rst_l = 1'b0;
    #1;
    chk("rs_outputs_zero", all_out, 0);
    tick(); tick();
    rst_l = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rs_quiet_%0d", k), {rd_valid_o, ic_debug_rd_en, ic_debug_wr_en, busy}, 0);
    end
    chk("final_valid_count", vcnt, 3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_ic_diag_ctl.md
Name: ifu_ic_diag_ctl

Overview:
- IFU-side responder for the I-cache diagnostic packet driven by the TLU (dec_tlu_ic_diag_pkt fields).
- Accepts one debug read or write of a tag or data array entry and arbitrates the array against instruction fetch.
- Issues a single-cycle array access, then returns read data to the TLU with a one-cycle valid pulse.
- Sits in ifu, between dec_tlu_ctl and the I-cache array wrapper; it drives ic_debug_addr and its companion strobes.

Parameters:
IDX_W, 9, I-cache set index width
WAYS, 4, associativity (power of 2, ≥2)
DATA_W, 71, diag read/write data width (data + ECC)
RD_LAT, 2, array read latency in cycles (≥1)
STARVE_LIM, 15, max ARB cycles before fetch hold is requested

Ports:
clk  in  1  core clock
rst_l  in  1  async active-low reset
dec_tlu_ic_diag_rd_valid  in  1  read request pulse
dec_tlu_ic_diag_wr_valid  in  1  write request pulse
dec_tlu_ic_diag_tag_sel  in  1  0=data array, 1=tag array
dec_tlu_ic_diag_way  in  $clog2(WAYS)  target way (binary)
dec_tlu_ic_diag_index  in  IDX_W  target set
dec_tlu_ic_diag_wrdata  in  DATA_W  write data
ifc_fetch_active  in  1  fetch owns the array this cycle
ic_array_rd_data  in  DATA_W  array read return
ic_debug_rd_en  out  1  array read strobe
ic_debug_wr_en  out  1  array write strobe
ic_debug_tag_array  out  1  array select
ic_debug_way  out  WAYS  one-hot way enable
ic_debug_addr  out  IDX_W  set index
ic_debug_wr_data  out  DATA_W  write data
ifu_ic_diag_fetch_hold  out  1  request fetch stall
ifu_ic_debug_rd_data  out  DATA_W  captured read data
ifu_ic_debug_rd_data_valid  out  1  read data valid pulse
ifu_ic_diag_busy  out  1  request in flight
ifu_ic_diag_err  out  1  dropped-request pulse

Behaviour:
- Clock is clk, reset is rst_l: asynchronous, active-low. In reset, state=IDLE, all outputs 0, captured request/data regs 0, counters 0.
- All outputs are registered.
- States: IDLE, ARB, ISSUE, WAIT, RESP.
- IDLE: a rd_valid or wr_valid at cycle N captures op/sel/way/index/wrdata; next state ARB; busy=1 from N+1.
  - If both valids are high, the write is taken, the read is dropped, and err pulses at N+1.
- ARB: each cycle increments starve_cnt (saturating).
  - When starve_cnt reaches STARVE_LIM, fetch_hold=1 and stays 1 until the state leaves ISSUE.
  - In the first ARB cycle that samples ifc_fetch_active=0, the next state is ISSUE.
- ISSUE (exactly one cycle): rd_en or wr_en=1, plus tag_array, one-hot way, addr, and wr_data (write only; otherwise 0).
  - Strobes are 0 in every other state. starve_cnt clears.
  - After a write, next state is IDLE and busy drops in the following cycle.
  - After a read, next state is WAIT.
- WAIT: counts RD_LAT cycles after ISSUE. ic_array_rd_data is sampled in the cycle that is exactly RD_LAT cycles after ISSUE. Next state is RESP.
- RESP (one cycle): rd_data_valid=1 with ifu_ic_debug_rd_data = sampled value.
  - rd_data holds that value until the next read's RESP.
  - Next state is IDLE; busy=0 from the next cycle.
- Uncontended read latency: accept N → ISSUE N+2 → valid N+3+RD_LAT.
- Any rd/wr valid that arrives while busy (state≠IDLE) is dropped with err pulsing one cycle; state is unaffected.
- Way decode: ic_debug_way = 1<<way.
- A reset asserted mid-operation aborts immediately. No strobe or valid is produced for the aborted request after release.

Decomposition:
- Shared package ifu_pkg holds:
  - the state enum ic_diag_state_e;
  - the struct ic_diag_pkt_t (rd_valid, wr_valid, tag_sel, way, index, wrdata);
  - the defaults for IDX_W/WAYS/DATA_W.
- One natural sub-module: ifu_ic_diag_lat_cnt, a RD_LAT down-counter with a done pulse. Everything else stays flat.

Test Plan:
- Uncontended read, RD_LAT=2, way=2, index=0x1A5, tag_sel=1, fetch idle, array returns 0x3F at the sample cycle → rd_en at N+2 with way=4'b0100 and addr=0x1A5; valid pulse at N+5 with data 0x3F.
- Write with fetch idle, wrdata=0x12345 → wr_en one cycle at N+2 with wr_data=0x12345; busy=0 at N+4; no valid pulse.
- Read with fetch_active held high 20 cycles → fetch_hold=1 after 15 ARB cycles; ISSUE one cycle after fetch_active falls; fetch_hold clears after ISSUE.
- Simultaneous rd_valid+wr_valid → only wr_en issued; err=1 at N+1.
- Second read request during WAIT → err pulse; first read completes with correct data; no second access.
- rst_l low during WAIT → all outputs 0 immediately; after release, no rd_data_valid, state IDLE.
